in_chan_buffer: RTL and testbench

IN_CHAN_BUFFER -- requirements
Module: in_chan_buffer

---
 rtl/in_chan_buffer_pkg.sv | 29 ++
 rtl/in_chan_buffer_if.sv | 33 +++
 rtl/fifo_sync.sv | 49 ++++
 rtl/in_chan_buffer.sv | 133 +++++++++++++
 tb/tb_in_chan_buffer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/in_chan_buffer_pkg.sv
// Shared NoC definitions for the router input channel: flit ID codes,
// output port encoding and input-channel FSM state encoding.
package in_chan_buffer_pkg;

  typedef enum logic [1:0] {
    FLIT_INV  = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_id_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTE  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Width of a routed output port index for a 5-port router.
  localparam int unsigned PORT_IDX_W = 3;

endpackage

// File: rtl/in_chan_buffer_if.sv
// Input-channel bus: upstream link (data_i/wr_en_i/rdy_o) and the
// allocator/crossbar side (head flit, routing result, grant, pop, error).
//   slave  : seen by in_chan_buffer
//   master : seen by the upstream link / allocator driving the buffer
interface in_chan_buffer_if
  import in_chan_buffer_pkg::*;
#(
  parameter int FLIT_W    = 8,
  parameter int FLIT_ID_W = 2,
  parameter int RES_W     = PORT_IDX_W
);
  logic [FLIT_W-1:0]    data_i;
  logic                 wr_en_i;
  logic                 rdy_o;
  logic [FLIT_W-1:0]    data_o;
  logic [FLIT_ID_W-1:0] flit_id_o;
  logic                 data_vld_o;
  logic [RES_W-1:0]     rtr_res_o;
  logic                 rtr_res_vld_o;
  logic                 chan_alloc_i;
  logic                 rd_en_i;
  logic                 err_o;

  modport slave (
    input  data_i, wr_en_i, chan_alloc_i, rd_en_i,
    output rdy_o, data_o, flit_id_o, data_vld_o, rtr_res_o, rtr_res_vld_o, err_o
  );

  modport master (
    output data_i, wr_en_i, chan_alloc_i, rd_en_i,
    input  rdy_o, data_o, flit_id_o, data_vld_o, rtr_res_o, rtr_res_vld_o, err_o
  );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO, 2^DEPTH_W entries, first-word fall-through read port.
// Ports: i_clk, i_rst (sync, active-high), i_wr_en/i_wr_data (write),
//        i_rd_en (pop), o_rd_data (head entry), o_full, o_empty.
// A write while full is accepted only when a pop happens in the same cycle.
module fifo_sync #(
  parameter int DATA_W  = 8,
  parameter int DEPTH_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH_W:0]  r_wr_ptr;
  logic [DEPTH_W:0]  r_rd_ptr;
  logic              w_wr;
  logic              w_rd;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_W] != r_rd_ptr[DEPTH_W]) &&
                   (r_wr_ptr[DEPTH_W-1:0] == r_rd_ptr[DEPTH_W-1:0]);

  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[DEPTH_W-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[DEPTH_W-1:0]];
endmodule

// File: rtl/in_chan_buffer.sv
// Router input channel: flit FIFO plus packet FSM (IDLE/ROUTE/ACTIVE) with
// XY (column-first) route computation for the packet at the FIFO head.
// Ports: clk_i, rst_i (sync, active-high); bus (in_chan_buffer_if.slave):
//   data_i/wr_en_i/rdy_o upstream link, data_o/flit_id_o/data_vld_o head flit,
//   rtr_res_o/rtr_res_vld_o routed port, chan_alloc_i/rd_en_i pop, err_o.
module in_chan_buffer
  import in_chan_buffer_pkg::*;
#(
  parameter int FLIT_W         = 8,
  parameter int FLIT_ID_W      = 2,
  parameter int BUFFER_DEPTH_W = 2,
  parameter int ROW_CORD       = 0,
  parameter int COL_CORD       = 0,
  parameter int ROW_ADDR_W     = 2,
  parameter int COL_ADDR_W     = 2,
  parameter int OUT_M          = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  in_chan_buffer_if.slave  bus
);
  localparam int unsigned RES_W = $clog2(OUT_M);
  localparam logic [ROW_ADDR_W-1:0] L_ROW = ROW_ADDR_W'(ROW_CORD);
  localparam logic [COL_ADDR_W-1:0] L_COL = COL_ADDR_W'(COL_CORD);

  state_e               r_state, w_state_nxt;
  logic [FLIT_W-1:0]    w_head;
  logic [FLIT_ID_W-1:0] w_id;
  logic                 w_full, w_empty, w_vld;
  logic                 w_is_head, w_is_tail;
  logic                 w_user_pop, w_drop, w_pop, w_wr, w_rdy;
  logic                 w_err, w_route_ld, w_done;
  logic [ROW_ADDR_W-1:0] w_drow;
  logic [COL_ADDR_W-1:0] w_dcol;
  logic [RES_W-1:0]     w_xy, r_res;
  logic                 r_res_vld;
  logic                 r_own_head;    // current packet's HEAD still queued
  logic                 r_hd_err_seen; // stray HEAD at head already reported

  fifo_sync #(.DATA_W(FLIT_W), .DEPTH_W(BUFFER_DEPTH_W)) u_fifo (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_wr_en   (w_wr),
    .i_wr_data (bus.data_i),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_vld      = !w_empty && !rst_i;
  assign w_id       = w_head[FLIT_W-1 -: FLIT_ID_W];
  assign w_is_head  = (w_id == FLIT_ID_W'(FLIT_HEAD));
  assign w_is_tail  = (w_id == FLIT_ID_W'(FLIT_TAIL));
  assign w_user_pop = (r_state == ST_ACTIVE) && bus.rd_en_i && bus.chan_alloc_i && w_vld;
  assign w_pop      = w_user_pop || w_drop;
  // A pop frees a slot this cycle, so a full FIFO can still take a write.
  assign w_rdy      = rst_i || !w_full || w_pop;
  assign w_wr       = bus.wr_en_i && w_rdy && !rst_i;

  assign w_dcol = w_head[COL_ADDR_W-1:0];
  assign w_drow = w_head[COL_ADDR_W +: ROW_ADDR_W];

  always_comb begin
    if      (w_dcol > L_COL) w_xy = RES_W'(PORT_EAST);
    else if (w_dcol < L_COL) w_xy = RES_W'(PORT_WEST);
    else if (w_drow > L_ROW) w_xy = RES_W'(PORT_SOUTH);
    else if (w_drow < L_ROW) w_xy = RES_W'(PORT_NORTH);
    else                     w_xy = RES_W'(PORT_LOCAL);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop      = 1'b0;
    w_err       = 1'b0;
    w_route_ld  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vld) begin
          if (w_is_head) begin
            w_state_nxt = ST_ROUTE;
          end else begin
            w_drop = 1'b1;
            w_err  = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        w_route_ld  = 1'b1;
        w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A HEAD other than the packet's own is forwarded as BODY.
        w_err = w_vld && w_is_head && !r_own_head && !r_hd_err_seen;
        if (w_user_pop && w_is_tail) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_res         <= '0;
      r_res_vld     <= 1'b0;
      r_own_head    <= 1'b0;
      r_hd_err_seen <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hd_err_seen <= (r_state == ST_ACTIVE) && w_vld && w_is_head &&
                       !r_own_head && !w_user_pop;
      if (w_route_ld) begin
        r_res      <= w_xy;
        r_res_vld  <= 1'b1;
        r_own_head <= 1'b1;
      end
      if (w_user_pop) r_own_head <= 1'b0;
      if (w_done)     r_res_vld  <= 1'b0;
    end
  end

  assign bus.rdy_o         = w_rdy;
  assign bus.data_o        = w_head;
  assign bus.flit_id_o     = w_id;
  assign bus.data_vld_o    = w_vld;
  assign bus.rtr_res_o     = rst_i ? '0 : r_res;
  assign bus.rtr_res_vld_o = r_res_vld && !rst_i;
  assign bus.err_o         = w_err;
endmodule

// File: tb/tb_in_chan_buffer.sv
// Directed bench for in_chan_buffer at router (1,1); flits are
// {id[7:6], 2'b00/pad, row[3:2], col[1:0]} for HEADs.
module tb_in_chan_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  in_chan_buffer_if #(.FLIT_W(8), .FLIT_ID_W(2), .RES_W(3)) bus ();

  in_chan_buffer #(
    .FLIT_W(8), .FLIT_ID_W(2), .BUFFER_DEPTH_W(2),
    .ROW_CORD(1), .COL_CORD(1), .ROW_ADDR_W(2), .COL_ADDR_W(2), .OUT_M(5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.data_i       = '0;
    bus.wr_en_i      = 1'b0;
    bus.rd_en_i      = 1'b0;
    bus.chan_alloc_i = 1'b0;
  endtask

  // XY reference for a router at row 1, col 1: L=0 N=1 E=2 S=3 W=4.
  function automatic logic [2:0] ref_route(input int row, input int col);
    if (col > 1) return 3'd2;
    if (col < 1) return 3'd4;
    if (row > 1) return 3'd3;
    if (row < 1) return 3'd1;
    return 3'd0;
  endfunction

  // Drive a write; scoreboard takes it when the 4-deep buffer has room.
  task automatic write_flit(input logic [7:0] f, input bit popping);
    bus.data_i  = f;
    bus.wr_en_i = 1'b1;
    if (exp_q.size() < 4 || popping) exp_q.push_back(f);
  endtask

  task automatic lat_check(input int e, input logic [2:0] exp_res, input logic [7:0] hd);
    #1;
    if (e == 1) begin
      chk("head_visible", bus.data_o, hd);
      chk("vld_after_write", bus.data_vld_o, 1);
      chk("res_vld_lat0", bus.rtr_res_vld_o, 0);
    end
    if (e == 2) chk("res_vld_lat1", bus.rtr_res_vld_o, 0);
    if (e == 3) begin
      chk("res_vld_lat2", bus.rtr_res_vld_o, 1);
      chk("rtr_res", bus.rtr_res_o, exp_res);
    end
  endtask

  task automatic load(input logic [7:0] f[$], input logic [2:0] exp_res);
    int e = 0;
    for (int k = 0; k < f.size(); k++) begin
      write_flit(f[k], 1'b0);
      tick();
      e++;
      bus.wr_en_i = 1'b0;
      lat_check(e, exp_res, f[0]);
    end
    while (e < 3) begin
      tick();
      e++;
      lat_check(e, exp_res, f[0]);
    end
  endtask

  task automatic drain(input logic [2:0] exp_res);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus.rd_en_i      = 1'b1;
      bus.chan_alloc_i = 1'b1;
      #1;
      chk("pop_data_vld", bus.data_vld_o, 1);
      chk("pop_data", bus.data_o, exp_q[0]);
      chk("res_stable", bus.rtr_res_o, exp_res);
      chk("res_vld_active", bus.rtr_res_vld_o, 1);
      chk("no_err_active", bus.err_o, 0);
      void'(exp_q.pop_front());
      tick();
    end
    bus.rd_en_i      = 1'b0;
    bus.chan_alloc_i = 1'b0;
    #1;
    chk("res_vld_cleared", bus.rtr_res_vld_o, 0);
    chk("empty_after_tail", bus.data_vld_o, 0);
  endtask

  task automatic run_pkt(input int row, input int col, input int nbody);
    logic [7:0] f [$];
    logic [1:0] r2 = 2'(row);
    logic [1:0] c2 = 2'(col);
    f.push_back({2'b01, 2'b00, r2, c2});
    for (int b = 0; b < nbody; b++) f.push_back({2'b10, 6'(b + 1)});
    f.push_back(8'hEA);
    load(f, ref_route(row, col));
    drain(ref_route(row, col));
  endtask

  initial begin
    logic [7:0] fq [$];
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_rdy", bus.rdy_o, 1);
    chk("rst_data_vld", bus.data_vld_o, 0);
    chk("rst_res_vld", bus.rtr_res_vld_o, 0);
    chk("rst_res", bus.rtr_res_o, 0);
    chk("rst_err", bus.err_o, 0);
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_rdy", bus.rdy_o, 1);
    chk("post_rst_vld", bus.data_vld_o, 0);

    // Packet to (1,3): EAST, one BODY.
    run_pkt(1, 3, 1);
    // Route table around (1,1).
    run_pkt(0, 1, 0);
    run_pkt(2, 1, 2);
    run_pkt(1, 0, 0);
    run_pkt(1, 1, 0);

    // Fill: 5 back-to-back writes into depth 4, 5th dropped.
    fq = {8'h45, 8'h81, 8'h82, 8'h83, 8'hC0};
    for (int k = 0; k < 5; k++) begin
      write_flit(fq[k], 1'b0);
      #1;
      if (k == 4) chk("rdy_full_pre5", bus.rdy_o, 0);
      tick();
      bus.wr_en_i = 1'b0;
      #1;
      if (k == 3) chk("rdy_after4", bus.rdy_o, 0);
    end
    // Full: simultaneous write and pop keeps occupancy at 4.
    write_flit(8'h84, 1'b1);
    bus.rd_en_i      = 1'b1;
    bus.chan_alloc_i = 1'b1;
    #1;
    chk("rdy_with_pop", bus.rdy_o, 1);
    chk("full_pop_data", bus.data_o, exp_q[0]);
    void'(exp_q.pop_front());
    tick();
    idle_in();
    #1;
    chk("still_full", bus.rdy_o, 0);
    chk("order_after_simul", bus.data_o, exp_q[0]);
    write_flit(8'hC5, 1'b1);
    bus.rd_en_i      = 1'b1;
    bus.chan_alloc_i = 1'b1;
    #1;
    chk("simul2_data", bus.data_o, exp_q[0]);
    void'(exp_q.pop_front());
    tick();
    bus.wr_en_i = 1'b0;
    drain(3'd0);

    // BODY into an idle buffer: error pulse, flit discarded.
    bus.data_i  = 8'h85;
    bus.wr_en_i = 1'b1;
    tick();
    bus.wr_en_i = 1'b0;
    #1;
    chk("idle_body_err", bus.err_o, 1);
    chk("idle_body_no_route", bus.rtr_res_vld_o, 0);
    tick();
    #1;
    chk("idle_err_one_cycle", bus.err_o, 0);
    chk("idle_body_discarded", bus.data_vld_o, 0);
    run_pkt(0, 1, 0);

    // Stray HEAD inside an active packet: one err pulse, forwarded as BODY.
    fq = {8'h47, 8'h4B, 8'hC7};
    load(fq, 3'd2);
    bus.rd_en_i      = 1'b1;
    bus.chan_alloc_i = 1'b1;
    #1;
    chk("own_head_no_err", bus.err_o, 0);
    void'(exp_q.pop_front());
    tick();
    bus.rd_en_i      = 1'b0;
    bus.chan_alloc_i = 1'b0;
    #1;
    chk("stray_head_err", bus.err_o, 1);
    chk("stray_head_data", bus.data_o, 8'h4B);
    tick();
    #1;
    chk("stray_err_pulse", bus.err_o, 0);
    drain(3'd2);

    // Reset mid-packet.
    fq = {8'h47, 8'h81};
    load(fq, 3'd2);
    rst = 1'b1;
    #1;
    chk("midrst_err_during", bus.err_o, 0);
    chk("midrst_rdy_during", bus.rdy_o, 1);
    tick();
    #1;
    chk("midrst_data_vld", bus.data_vld_o, 0);
    chk("midrst_res_vld", bus.rtr_res_vld_o, 0);
    chk("midrst_rdy", bus.rdy_o, 1);
    chk("midrst_err", bus.err_o, 0);
    chk("midrst_res", bus.rtr_res_o, 0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    #1;
    chk("after_rst_vld", bus.data_vld_o, 0);
    chk("after_rst_err", bus.err_o, 0);
    run_pkt(2, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
